// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default virtual-channel geometry and the
// encoding of the output-port arbiter states.
package noc_pkg;

  localparam int NUM_VC_DEF = 8;
  localparam int VC_W_DEF   = 3;
  localparam int CNT_W_DEF  = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/vc_rr_pick.sv
// Round-robin pick: first set request at or after rrPtr, wrapping at NUM_VC.
// Purely combinational; found=0 means no request is pending.
module vc_rr_pick
  import noc_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF
) (
  input  logic [NUM_VC-1:0] requests,
  input  logic [VC_W-1:0]   rrPtr,
  output logic              found,
  output logic [VC_W-1:0]   pickIdx
);

  logic [NUM_VC-1:0] rot_s;

  // Rotate so the pointer position lands at bit 0, encode, then un-rotate.
  always_comb begin
    int ptr_v;
    int src_v;
    int off_v;
    int sum_v;
    ptr_v = int'(rrPtr);
    src_v = 0;
    off_v = 0;
    sum_v = 0;
    rot_s = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      src_v    = ((i + ptr_v) >= NUM_VC) ? (i + ptr_v - NUM_VC) : (i + ptr_v);
      rot_s[i] = requests[src_v];
    end
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_v = i;
      end else begin
      end
    end
    sum_v   = ((off_v + ptr_v) >= NUM_VC) ? (off_v + ptr_v - NUM_VC) : (off_v + ptr_v);
    found   = |rot_s;
    pickIdx = VC_W'(sum_v);
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Output-port virtual-channel arbiter: grants one VC round-robin and holds it
// until the packet tail transfers, then advances the pointer past the winner.
module vc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_VC-1:0] vc_isNew,
  input  logic              flitValid,
  input  logic              flitTail,
  input  logic              outReady,
  output logic              isNew,
  output logic              grantValid,
  output logic [VC_W-1:0]   grantVc,
  output logic [NUM_VC-1:0] grantOneHot,
  output logic              popVc,
  output logic [CNT_W-1:0]  flitCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [VC_W-1:0]  LAST_VC = VC_W'(NUM_VC - 1);

  logic [0:0]        state_q, state_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              grant_valid_q, grant_valid_d;
  logic [VC_W-1:0]   grant_vc_q, grant_vc_d;
  logic [NUM_VC-1:0] grant_onehot_q, grant_onehot_d;
  logic [CNT_W-1:0]  flit_count_q, flit_count_d;

  logic              pick_found_s;
  logic [VC_W-1:0]   pick_idx_s;
  logic              pop_s;

  vc_rr_pick #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_pick (
    .requests (vc_isNew),
    .rrPtr    (rr_ptr_q),
    .found    (pick_found_s),
    .pickIdx  (pick_idx_s)
  );

  assign pop_s       = grant_valid_q & flitValid & outReady;
  assign isNew       = |vc_isNew;
  assign popVc       = pop_s;
  assign grantValid  = grant_valid_q;
  assign grantVc     = grant_vc_q;
  assign grantOneHot = grant_onehot_q;
  assign flitCount   = flit_count_q;

  // Requests are only looked at in IDLE, so a grant is never preempted.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_valid_d  = grant_valid_q;
    grant_vc_d     = grant_vc_q;
    grant_onehot_d = grant_onehot_q;
    flit_count_d   = flit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d       = ST_BUSY;
          grant_valid_d = 1'b1;
          grant_vc_d    = pick_idx_s;
          flit_count_d  = '0;
          for (int i = 0; i < NUM_VC; i++) begin
            grant_onehot_d[i] = (pick_idx_s == VC_W'(i));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (pop_s) begin
          if (flit_count_q != CNT_MAX) begin
            flit_count_d = flit_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            flit_count_d = flit_count_q;
          end
          if (flitTail) begin
            state_d        = ST_IDLE;
            grant_valid_d  = 1'b0;
            grant_onehot_d = '0;
            rr_ptr_d       = (grant_vc_q == LAST_VC) ? '0 : grant_vc_q + {{(VC_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_valid_q  <= 1'b0;
      grant_vc_q     <= '0;
      grant_onehot_q <= '0;
      flit_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_valid_q  <= grant_valid_d;
      grant_vc_q     <= grant_vc_d;
      grant_onehot_q <= grant_onehot_d;
      flit_count_q   <= flit_count_d;
    end
  end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Bench for vc_rr_arbiter: directed scenarios then random traffic, all checked
// against a packet-level round-robin reference model.
module tb_vc_rr_arbiter;

  localparam int N    = 8;
  localparam int CMAX = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] vc_isNew;
  logic         flitValid;
  logic         flitTail;
  logic         outReady;
  logic         isNew;
  logic         grantValid;
  logic [2:0]   grantVc;
  logic [N-1:0] grantOneHot;
  logic         popVc;
  logic [7:0]   flitCount;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_busy;
  int m_ptr;
  int m_vc;
  int m_cnt;

  always #5 clk = ~clk;

  vc_rr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .vc_isNew    (vc_isNew),
    .flitValid   (flitValid),
    .flitTail    (flitTail),
    .outReady    (outReady),
    .isNew       (isNew),
    .grantValid  (grantValid),
    .grantVc     (grantVc),
    .grantOneHot (grantOneHot),
    .popVc       (popVc),
    .flitCount   (flitCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_vc   = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_ptr + j) % N;
        if (vc_isNew[k]) begin
          m_busy = 1'b1;
          m_vc   = k;
          m_cnt  = 0;
          break;
        end
      end
    end else if (flitValid && outReady) begin
      if (m_cnt < CMAX) m_cnt++;
      if (flitTail) begin
        m_busy = 1'b0;
        m_ptr  = (m_vc + 1) % N;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] oh;
    oh = m_busy ? (32'd1 << m_vc) : 32'd0;
    chk("isNew",       32'(isNew),       32'(|vc_isNew));
    chk("grantValid",  32'(grantValid),  32'(m_busy));
    chk("grantVc",     32'(grantVc),     32'(m_vc));
    chk("grantOneHot", 32'(grantOneHot), oh);
    chk("popVc",       32'(popVc),       32'(m_busy && flitValid && outReady));
    chk("flitCount",   32'(flitCount),   32'(m_cnt));
  endtask

  // One clock: drive inputs, check at the falling edge, then update the model.
  task automatic step(input logic [N-1:0] v, input logic fv, input logic tl,
                      input logic rdy, input logic rs);
    vc_isNew  = v;
    flitValid = fv;
    flitTail  = tl;
    outReady  = rdy;
    rst       = rs;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    vc_isNew  = '0;
    flitValid = 1'b0;
    flitTail  = 1'b0;
    outReady  = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // reset state
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_gv", 32'(grantValid), 32'd0);
    chk("rst_fc", 32'(flitCount), 32'd0);

    // single request on VC2, three-flit packet
    step(8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_vc", 32'(grantVc), 32'd2);
    chk("t1_oh", 32'(grantOneHot), 32'h04);
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_rel", 32'(grantValid), 32'd0);
    chk("t2_fc", 32'(flitCount), 32'd3);

    // pointer at 3, requests 0 and 2: wrap picks VC0
    step(8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_vc", 32'(grantVc), 32'd0);
    step(8'h05, 1'b1, 1'b1, 1'b1, 1'b0);

    // walk pointer to 7, then VC7 single-flit packets back to back
    step(8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_vc", 32'(grantVc), 32'd7);
    step(8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_bubble", 32'(grantValid), 32'd0);
    step(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_regrant", 32'(grantVc), 32'd7);
    step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // stall on VC1 while everyone requests, then reset mid-packet
    step(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_hold", 32'(grantVc), 32'd1);
    repeat (5) step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_fc5", 32'(flitCount), 32'd5);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_gv", 32'(grantValid), 32'd0);
    step(8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_vc", 32'(grantVc), 32'd4);
    step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // long packet saturates the flit counter
    step(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (260) step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_fc", 32'(flitCount), 32'd255);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      v = ($urandom % 4 == 0) ? '0 : N'($urandom & $urandom);
      step(v, ($urandom % 4) != 0, ($urandom % 3) == 0,
           ($urandom % 4) != 0, ($urandom % 200) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
